// File: rtl/alu_issue_stage_if.sv
// Operand/control bundle between register read, the issue stage and the ALU.
// The stage takes the master view; the surrounding pipeline takes the slave view.
interface alu_issue_stage_if #(
    parameter int COUNT_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        instr;
    logic [31:0]        rs_data;
    logic [31:0]        rt_data;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        alu_a;
    logic [31:0]        alu_b;
    logic [2:0]         alu_control;
    logic [4:0]         dest_reg;
    logic               reg_write;
    logic               illegal;
    logic [COUNT_W-1:0] issued_count;

    modport master (
        input  in_valid, instr, rs_data, rt_data, flush, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_control,
               dest_reg, reg_write, illegal, issued_count
    );

    modport slave (
        output in_valid, instr, rs_data, rt_data, flush, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_control,
               dest_reg, reg_write, illegal, issued_count
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Register-read to ALU issue stage: decodes the MIPS instruction into ALU control,
// picks operand B and holds one registered entry behind a valid/ready handshake.
module alu_issue_stage #(
    parameter int         COUNT_W      = 16,
    parameter logic [2:0] ILLEGAL_CTRL = 3'b010
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_issue_stage_if.master  bus
);

    logic [5:0]         opcode_s;
    logic [5:0]         funct_s;
    logic [31:0]        imm_sx_s;
    logic [31:0]        imm_zx_s;
    logic               dec_legal_s;
    logic [2:0]         dec_ctrl_s;
    logic [31:0]        dec_b_s;
    logic [4:0]         dec_dest_s;
    logic               dec_write_s;

    logic [31:0]        nxt_a_s;
    logic [31:0]        nxt_b_s;
    logic [2:0]         nxt_ctrl_s;
    logic [4:0]         nxt_dest_s;
    logic               nxt_write_s;
    logic               nxt_illegal_s;

    logic               in_ready_s;
    logic               capture_s;
    logic               xfer_s;

    logic               out_valid_r;
    logic [31:0]        alu_a_r;
    logic [31:0]        alu_b_r;
    logic [2:0]         alu_control_r;
    logic [4:0]         dest_reg_r;
    logic               reg_write_r;
    logic               illegal_r;
    logic [COUNT_W-1:0] issued_count_r;

    assign opcode_s = bus.instr[31:26];
    assign funct_s  = bus.instr[5:0];
    assign imm_sx_s = {{16{bus.instr[15]}}, bus.instr[15:0]};
    assign imm_zx_s = {16'h0000, bus.instr[15:0]};

    // Opcode/funct decode into ALU control, operand B source and writeback target.
    always_comb begin
        dec_legal_s = 1'b1;
        dec_ctrl_s  = 3'b010;
        dec_b_s     = 32'h0000_0000;
        dec_dest_s  = 5'd0;
        dec_write_s = 1'b0;
        case (opcode_s)
            6'b000000: begin
                dec_b_s     = bus.rt_data;
                dec_dest_s  = bus.instr[15:11];
                dec_write_s = 1'b1;
                case (funct_s)
                    6'b100000, 6'b100001: dec_ctrl_s = 3'b010;
                    6'b100010, 6'b100011: dec_ctrl_s = 3'b110;
                    6'b100100:            dec_ctrl_s = 3'b000;
                    6'b100101:            dec_ctrl_s = 3'b001;
                    6'b101010:            dec_ctrl_s = 3'b111;
                    default:              dec_legal_s = 1'b0;
                endcase
            end
            6'b001000: begin dec_ctrl_s = 3'b010; dec_b_s = imm_sx_s; dec_dest_s = bus.instr[20:16]; dec_write_s = 1'b1; end
            6'b001010: begin dec_ctrl_s = 3'b111; dec_b_s = imm_sx_s; dec_dest_s = bus.instr[20:16]; dec_write_s = 1'b1; end
            6'b001100: begin dec_ctrl_s = 3'b000; dec_b_s = imm_zx_s; dec_dest_s = bus.instr[20:16]; dec_write_s = 1'b1; end
            6'b001101: begin dec_ctrl_s = 3'b001; dec_b_s = imm_zx_s; dec_dest_s = bus.instr[20:16]; dec_write_s = 1'b1; end
            6'b100011: begin dec_ctrl_s = 3'b010; dec_b_s = imm_sx_s; dec_dest_s = bus.instr[20:16]; dec_write_s = 1'b1; end
            6'b101011: begin dec_ctrl_s = 3'b010; dec_b_s = imm_sx_s; end
            6'b000100: begin dec_ctrl_s = 3'b110; dec_b_s = bus.rt_data; end
            default:   dec_legal_s = 1'b0;
        endcase
    end

    // Final entry: illegal instructions carry a zeroed payload; writes to $0 are suppressed.
    always_comb begin
        if (dec_legal_s) begin
            nxt_a_s       = bus.rs_data;
            nxt_b_s       = dec_b_s;
            nxt_ctrl_s    = dec_ctrl_s;
            nxt_dest_s    = dec_dest_s;
            nxt_write_s   = dec_write_s && (dec_dest_s != 5'd0);
            nxt_illegal_s = 1'b0;
        end else begin
            nxt_a_s       = 32'h0000_0000;
            nxt_b_s       = 32'h0000_0000;
            nxt_ctrl_s    = ILLEGAL_CTRL;
            nxt_dest_s    = 5'd0;
            nxt_write_s   = 1'b0;
            nxt_illegal_s = 1'b1;
        end
    end

    assign in_ready_s = !out_valid_r || bus.out_ready;
    assign capture_s  = bus.in_valid && in_ready_s && !bus.flush;
    assign xfer_s     = out_valid_r && bus.out_ready;

    // Pipeline register: flush kills the entry, capture loads, a lone transfer drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r    <= 1'b0;
            alu_a_r        <= 32'h0000_0000;
            alu_b_r        <= 32'h0000_0000;
            alu_control_r  <= 3'b000;
            dest_reg_r     <= 5'd0;
            reg_write_r    <= 1'b0;
            illegal_r      <= 1'b0;
            issued_count_r <= {COUNT_W{1'b0}};
        end else begin
            if (xfer_s) begin
                issued_count_r <= issued_count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
            end else begin
                issued_count_r <= issued_count_r;
            end
            if (bus.flush) begin
                out_valid_r <= 1'b0;
            end else if (capture_s) begin
                out_valid_r   <= 1'b1;
                alu_a_r       <= nxt_a_s;
                alu_b_r       <= nxt_b_s;
                alu_control_r <= nxt_ctrl_s;
                dest_reg_r    <= nxt_dest_s;
                reg_write_r   <= nxt_write_s;
                illegal_r     <= nxt_illegal_s;
            end else if (xfer_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign bus.in_ready     = in_ready_s;
    assign bus.out_valid    = out_valid_r;
    assign bus.alu_a        = alu_a_r;
    assign bus.alu_b        = alu_b_r;
    assign bus.alu_control  = alu_control_r;
    assign bus.dest_reg     = dest_reg_r;
    assign bus.reg_write    = reg_write_r;
    assign bus.illegal      = illegal_r;
    assign bus.issued_count = issued_count_r;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: expected entries go into a queue when offered
// and are compared against the registered outputs one cycle later.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  c;
        logic [4:0]  d;
        logic        w;
        logic        il;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    exp_t        q[$];
    exp_t        m_last;
    logic        m_valid;
    logic [15:0] m_count;

    alu_issue_stage_if #(.COUNT_W(16)) bus ();

    alu_issue_stage #(.COUNT_W(16), .ILLEGAL_CTRL(3'b010)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] f);
        return {6'b000000, rs, rt, rd, 5'b00000, f};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Reference decoder for the supported MIPS subset.
    function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] rs,
                                     input logic [31:0] rt);
        exp_t        e;
        logic        ok;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] sx;
        logic [31:0] zx;
        op = ins[31:26];
        fn = ins[5:0];
        sx = {{16{ins[15]}}, ins[15:0]};
        zx = {16'h0000, ins[15:0]};
        e  = '0;
        ok = 1'b1;
        e.a = rs;
        if (op == 6'b000000) begin
            e.b = rt; e.d = ins[15:11]; e.w = 1'b1;
            if (fn == 6'b100000 || fn == 6'b100001)      e.c = 3'b010;
            else if (fn == 6'b100010 || fn == 6'b100011) e.c = 3'b110;
            else if (fn == 6'b100100)                    e.c = 3'b000;
            else if (fn == 6'b100101)                    e.c = 3'b001;
            else if (fn == 6'b101010)                    e.c = 3'b111;
            else                                         ok  = 1'b0;
        end else if (op == 6'b001000) begin e.c = 3'b010; e.b = sx; e.d = ins[20:16]; e.w = 1'b1;
        end else if (op == 6'b001010) begin e.c = 3'b111; e.b = sx; e.d = ins[20:16]; e.w = 1'b1;
        end else if (op == 6'b001100) begin e.c = 3'b000; e.b = zx; e.d = ins[20:16]; e.w = 1'b1;
        end else if (op == 6'b001101) begin e.c = 3'b001; e.b = zx; e.d = ins[20:16]; e.w = 1'b1;
        end else if (op == 6'b100011) begin e.c = 3'b010; e.b = sx; e.d = ins[20:16]; e.w = 1'b1;
        end else if (op == 6'b101011) begin e.c = 3'b010; e.b = sx;
        end else if (op == 6'b000100) begin e.c = 3'b110; e.b = rt;
        end else ok = 1'b0;
        if (e.d == 5'd0) e.w = 1'b0;
        if (!ok) begin
            e    = '0;
            e.il = 1'b1;
            e.c  = 3'b010;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        exp_t cur;
        cur = (m_valid && q.size() > 0) ? q[0] : m_last;
        chk({tag, ".out_valid"}, {31'b0, bus.out_valid}, {31'b0, m_valid});
        chk({tag, ".count"},     {16'b0, bus.issued_count}, {16'b0, m_count});
        chk({tag, ".alu_a"},     bus.alu_a, cur.a);
        chk({tag, ".alu_b"},     bus.alu_b, cur.b);
        chk({tag, ".ctrl"},      {29'b0, bus.alu_control}, {29'b0, cur.c});
        chk({tag, ".dest"},      {27'b0, bus.dest_reg}, {27'b0, cur.d});
        chk({tag, ".reg_write"}, {31'b0, bus.reg_write}, {31'b0, cur.w});
        chk({tag, ".illegal"},   {31'b0, bus.illegal}, {31'b0, cur.il});
    endtask

    // One clock: drive at the falling edge, check in_ready, update model, check outputs next falling edge.
    task automatic step(input string tag, input logic v, input logic [31:0] ins,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic rdy, input logic fl);
        logic exp_rdy;
        logic accept;
        logic xfer;
        exp_t e;
        bus.in_valid  = v;
        bus.instr     = ins;
        bus.rs_data   = rs;
        bus.rt_data   = rt;
        bus.out_ready = rdy;
        bus.flush     = fl;
        #1;
        exp_rdy = !m_valid || rdy;
        chk({tag, ".in_ready"}, {31'b0, bus.in_ready}, {31'b0, exp_rdy});
        accept = v && exp_rdy && !fl;
        xfer   = m_valid && rdy;
        if (xfer) m_count = m_count + 16'd1;
        if (m_valid && (rdy || fl) && q.size() > 0) void'(q.pop_front());
        if (accept) begin
            e = ref_dec(ins, rs, rt);
            q.push_back(e);
            m_last = e;
        end
        if (fl)          m_valid = 1'b0;
        else if (accept) m_valid = 1'b1;
        else if (xfer)   m_valid = 1'b0;
        @(negedge clk);
        chk_outputs(tag);
    endtask

    task automatic idle(input string tag, input logic rdy);
        step(tag, 1'b0, 32'h0000_0000, 32'h0, 32'h0, rdy, 1'b0);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        m_valid = 1'b0;
        m_count = 16'h0000;
        m_last  = '0;
        rst_n   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.instr     = 32'h0;
        bus.rs_data   = 32'h0;
        bus.rt_data   = 32'h0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_outputs("reset");
        chk("reset.in_ready", {31'b0, bus.in_ready}, 32'h1);
        rst_n = 1'b1;
        @(negedge clk);

        // First add and its one-cycle latency, with literal expectations.
        step("add", 1'b1, 32'h0022_1820, 32'd5, 32'd7, 1'b1, 1'b0);
        chk("add.lit_a", bus.alu_a, 32'd5);
        chk("add.lit_b", bus.alu_b, 32'd7);
        chk("add.lit_ctrl", {29'b0, bus.alu_control}, 32'd2);
        chk("add.lit_dest", {27'b0, bus.dest_reg}, 32'd3);
        idle("add_drain", 1'b1);
        chk("add.lit_count", {16'b0, bus.issued_count}, 32'd1);

        step("addi", 1'b1, 32'h2024_FFFF, 32'd10, 32'd0, 1'b1, 1'b0);
        chk("addi.lit_b", bus.alu_b, 32'hFFFF_FFFF);
        step("ori", 1'b1, 32'h3424_FFFF, 32'd10, 32'd0, 1'b1, 1'b0);
        chk("ori.lit_b", bus.alu_b, 32'h0000_FFFF);
        chk("ori.lit_ctrl", {29'b0, bus.alu_control}, 32'd1);
        step("slti", 1'b1, i_ins(6'b001010, 5'd2, 5'd6, 16'h8000), 32'h1234, 32'h0, 1'b1, 1'b0);
        step("andi", 1'b1, i_ins(6'b001100, 5'd2, 5'd6, 16'h8001), 32'hF0F0, 32'h0, 1'b1, 1'b0);
        step("lw",   1'b1, i_ins(6'b100011, 5'd3, 5'd9, 16'hFFFC), 32'h100, 32'h0, 1'b1, 1'b0);
        step("sw",   1'b1, i_ins(6'b101011, 5'd3, 5'd9, 16'h0008), 32'h100, 32'h55, 1'b1, 1'b0);
        step("beq",  1'b1, i_ins(6'b000100, 5'd1, 5'd2, 16'h0003), 32'd4, 32'd4, 1'b1, 1'b0);
        chk("beq.lit_ctrl", {29'b0, bus.alu_control}, 32'd6);
        chk("beq.lit_wr", {31'b0, bus.reg_write}, 32'd0);

        // Back-to-back R-types with no bubbles.
        step("b2b_sub", 1'b1, r_ins(5'd1, 5'd2, 5'd4, 6'b100010), 32'd9, 32'd3, 1'b1, 1'b0);
        step("b2b_and", 1'b1, r_ins(5'd1, 5'd2, 5'd5, 6'b100100), 32'hFF00, 32'h0FF0, 1'b1, 1'b0);
        step("b2b_or",  1'b1, r_ins(5'd1, 5'd2, 5'd6, 6'b100101), 32'hFF00, 32'h0FF0, 1'b1, 1'b0);
        step("b2b_slt", 1'b1, r_ins(5'd1, 5'd2, 5'd7, 6'b101010), 32'd1, 32'd2, 1'b1, 1'b0);
        chk("slt.lit_ctrl", {29'b0, bus.alu_control}, 32'd7);
        step("addu",  1'b1, r_ins(5'd1, 5'd2, 5'd8, 6'b100001), 32'd1, 32'd2, 1'b1, 1'b0);
        step("subu",  1'b1, r_ins(5'd1, 5'd2, 5'd8, 6'b100011), 32'd1, 32'd2, 1'b1, 1'b0);
        step("add_r0", 1'b1, r_ins(5'd1, 5'd2, 5'd0, 6'b100000), 32'd1, 32'd2, 1'b1, 1'b0);
        chk("add_r0.lit_wr", {31'b0, bus.reg_write}, 32'd0);
        step("sll", 1'b1, r_ins(5'd1, 5'd2, 5'd3, 6'b000000), 32'd1, 32'd2, 1'b1, 1'b0);
        chk("sll.lit_illegal", {31'b0, bus.illegal}, 32'd1);
        step("bad_op", 1'b1, 32'hFC00_0000, 32'd1, 32'd2, 1'b1, 1'b0);
        idle("drain", 1'b1);
        idle("quiet", 1'b0);

        // Back-pressure: entry held for three cycles while new inputs are offered.
        step("bp_load", 1'b1, r_ins(5'd1, 5'd2, 5'd10, 6'b100000), 32'd11, 32'd22, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step("bp_hold", 1'b1, r_ins(5'd3, 5'd4, 5'd11, 6'b100010), 32'd100 + i, 32'd1, 1'b0, 1'b0);
        step("bp_release", 1'b1, r_ins(5'd3, 5'd4, 5'd12, 6'b100101), 32'd7, 32'd8, 1'b1, 1'b0);
        idle("bp_drain", 1'b1);

        // Flush with held entry and concurrent input, then flush during a transfer.
        step("fl_load", 1'b1, r_ins(5'd1, 5'd2, 5'd13, 6'b100000), 32'd1, 32'd1, 1'b0, 1'b0);
        step("fl_hold", 1'b1, r_ins(5'd1, 5'd2, 5'd14, 6'b100000), 32'd2, 32'd2, 1'b0, 1'b1);
        step("fl_load2", 1'b1, r_ins(5'd1, 5'd2, 5'd15, 6'b100000), 32'd3, 32'd3, 1'b0, 1'b0);
        step("fl_xfer", 1'b1, r_ins(5'd1, 5'd2, 5'd16, 6'b100000), 32'd4, 32'd4, 1'b1, 1'b1);

        // Counter wrap from all-ones.
        for (int i = 0; i < 70000 && m_count != 16'hFFFF; i++)
            step("bulk", 1'b1, 32'h0022_1820, 32'd5, 32'd7, 1'b1, 1'b0);
        idle("pre_wrap", 1'b0);
        chk("wrap.pre", {16'b0, bus.issued_count}, 32'h0000_FFFF);
        idle("wrap", 1'b1);
        chk("wrap.zero", {16'b0, bus.issued_count}, 32'h0000_0000);

        // Asynchronous reset in the middle of a hold.
        step("rst_load", 1'b1, r_ins(5'd1, 5'd2, 5'd17, 6'b100000), 32'd9, 32'd9, 1'b0, 1'b0);
        step("rst_hold", 1'b1, r_ins(5'd1, 5'd2, 5'd18, 6'b100000), 32'd8, 32'd8, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        m_valid = 1'b0;
        m_count = 16'h0000;
        m_last  = '0;
        chk_outputs("async_rst");
        chk("async_rst.in_ready", {31'b0, bus.in_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        idle("post_rst", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
